// File: rtl/dcache_line_controller.sv
// rtl/dcache_line_controller.sv - serialises cache line writebacks and fills into single-word memory beats
module dcache_line_controller #(
  parameter int LINE_WORDS = 8,
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             miss_req,
  input  logic [ADDR_WIDTH-1:0]            miss_address,
  input  logic                             wb_req,
  input  logic [ADDR_WIDTH-1:0]            wb_address,
  input  logic [LINE_WORDS*WORD_WIDTH-1:0] wb_data,
  output logic [LINE_WORDS*WORD_WIDTH-1:0] line_data,
  output logic                             line_valid,
  output logic                             wb_ack,
  output logic                             busy,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_address,
  output logic [WORD_WIDTH-1:0]            mem_wdata,
  input  logic                             mem_ready,
  input  logic [WORD_WIDTH-1:0]            mem_rdata
);
  localparam int LINE_W = LINE_WORDS * WORD_WIDTH;
  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int BYTE_W = $clog2(WORD_WIDTH / 8);
  localparam int OFFS_W = BEAT_W + BYTE_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WB_BURST, FILL_BURST, DONE} state_t;

  state_t                     state_q, state_d;
  logic [BEAT_W-1:0]          beat_q, beat_d;
  logic [BEAT_W-1:0]          next_beat;
  logic [ADDR_WIDTH-OFFS_W-1:0] base_line_q, base_line_d;
  logic [LINE_W-1:0]          wb_data_q, wb_data_d;
  logic [LINE_W-1:0]          line_data_q, line_data_d;
  logic                       line_valid_q, line_valid_d;
  logic                       wb_ack_q, wb_ack_d;
  logic                       busy_q, busy_d;
  logic                       mem_req_q, mem_req_d;
  logic                       mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]      mem_address_q, mem_address_d;
  logic [WORD_WIDTH-1:0]      mem_wdata_q, mem_wdata_d;

  // Byte offset within the line is irrelevant: bursts always start at the line base.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{wb_address[OFFS_W-1:0], miss_address[OFFS_W-1:0]};

  // Next state and registered outputs; the first burst cycle only launches beat 0
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    next_beat     = beat_q + 1'b1;
    base_line_d   = base_line_q;
    wb_data_d     = wb_data_q;
    line_data_d   = line_data_q;
    line_valid_d  = 1'b0;
    wb_ack_d      = 1'b0;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (wb_req) begin
          state_d     = WB_BURST;
          base_line_d = wb_address[ADDR_WIDTH-1:OFFS_W];
          wb_data_d   = wb_data;
        end else if (miss_req) begin
          state_d     = FILL_BURST;
          base_line_d = miss_address[ADDR_WIDTH-1:OFFS_W];
        end
      end
      WB_BURST, FILL_BURST: begin
        if (!mem_req_q) begin
          mem_req_d     = 1'b1;
          mem_we_d      = (state_q == WB_BURST);
          mem_address_d = {base_line_q, beat_q, {BYTE_W{1'b0}}};
          mem_wdata_d   = (state_q == WB_BURST) ? wb_data_q[WORD_WIDTH*beat_q +: WORD_WIDTH] : '0;
        end else if (mem_ready) begin
          if (state_q == FILL_BURST) begin
            line_data_d[WORD_WIDTH*beat_q +: WORD_WIDTH] = mem_rdata;
          end
          if (beat_q == LAST_BEAT) begin
            state_d       = DONE;
            beat_d        = '0;
            mem_req_d     = 1'b0;
            mem_we_d      = 1'b0;
            mem_address_d = '0;
            mem_wdata_d   = '0;
            wb_ack_d      = (state_q == WB_BURST);
            line_valid_d  = (state_q == FILL_BURST);
          end else begin
            beat_d        = next_beat;
            mem_address_d = {base_line_q, next_beat, {BYTE_W{1'b0}}};
            mem_wdata_d   = (state_q == WB_BURST) ? wb_data_q[WORD_WIDTH*next_beat +: WORD_WIDTH] : '0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any burst and clears every capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      base_line_q   <= '0;
      wb_data_q     <= '0;
      line_data_q   <= '0;
      line_valid_q  <= 1'b0;
      wb_ack_q      <= 1'b0;
      busy_q        <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      base_line_q   <= base_line_d;
      wb_data_q     <= wb_data_d;
      line_data_q   <= line_data_d;
      line_valid_q  <= line_valid_d;
      wb_ack_q      <= wb_ack_d;
      busy_q        <= busy_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign line_data   = line_data_q;
  assign line_valid  = line_valid_q;
  assign wb_ack      = wb_ack_q;
  assign busy        = busy_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
endmodule

// File: tb/tb_dcache_line_controller.sv
// tb/tb_dcache_line_controller.sv - randomized self-checking bench for dcache_line_controller
module tb_dcache_line_controller;
  logic         clk;
  logic         reset;
  logic         miss_req;
  logic [31:0]  miss_address;
  logic         wb_req;
  logic [31:0]  wb_address;
  logic [255:0] wb_data;
  logic [255:0] line_data;
  logic         line_valid;
  logic         wb_ack;
  logic         busy;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_address;
  logic [31:0]  mem_wdata;
  logic         mem_ready;
  logic [31:0]  mem_rdata;

  int           n_cmp;
  int           n_bad;
  logic [255:0] m_line;

  dcache_line_controller dut (
    .clk          (clk),
    .reset        (reset),
    .miss_req     (miss_req),
    .miss_address (miss_address),
    .wb_req       (wb_req),
    .wb_address   (wb_address),
    .wb_data      (wb_data),
    .line_data    (line_data),
    .line_valid   (line_valid),
    .wb_ack       (wb_ack),
    .busy         (busy),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_mem_req"}, mem_req, 1'b0);
    check_eq({tag, "_wb_ack"}, wb_ack, 1'b0);
    check_eq({tag, "_line_valid"}, line_valid, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check_quiet(tag);
    check_eq({tag, "_mem_we"}, mem_we, 1'b0);
    check_eq({tag, "_mem_address"}, mem_address, 32'h0);
    check_eq({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    check_eq({tag, "_line_data"}, line_data, 256'h0);
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  // Acts as upstream cache and memory: a writeback (if any) is served before the fill.
  // mode 0: ready always 1, rdata 0xA0+beat; mode 1: ready 1,0,0 repeating; mode 2: random ready.
  task automatic run_txns(input bit do_wb, input bit do_fill, input logic [31:0] wa,
                          input logic [255:0] wd, input logic [31:0] ma, input int mode);
    bit           order[$];
    int           cyc, a_exp, beats, stalls, pat;
    bit           cur_wb, r, prev_stall, prev_we;
    logic [31:0]  base, prev_addr, prev_wdata;
    logic [255:0] fill_line;
    if (do_wb) order.push_back(1'b1);
    if (do_fill) order.push_back(1'b0);
    @(negedge clk);
    reset = 1'b0;
    wb_req = do_wb; wb_address = wa; wb_data = wd;
    miss_req = do_fill; miss_address = ma;
    mem_ready = 1'b0;
    cyc = 0; a_exp = 1; beats = 0; stalls = 0; pat = 0;
    prev_stall = 1'b0; prev_we = 1'b0; prev_addr = '0; prev_wdata = '0;
    fill_line = m_line;
    cur_wb = order[0];
    base = (cur_wb ? wa : ma) & 32'hFFFF_FFE0;
    while (order.size() != 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc < a_exp) begin
        check_quiet("gap");
      end else begin
        check_eq("busy_in_txn", busy, 1'b1);
        if (cyc == a_exp) check_eq("launch_mem_req", mem_req, 1'b0);
        if (mem_req) begin
          if (prev_stall) begin
            check_eq("stall_addr", mem_address, prev_addr);
            check_eq("stall_we", mem_we, prev_we);
            check_eq("stall_wdata", mem_wdata, prev_wdata);
          end
          check_eq("beat_we", mem_we, cur_wb);
          check_eq("beat_addr", mem_address, base + 32'(4 * beats));
          if (cur_wb) check_eq("beat_wdata", mem_wdata, wd[32*(beats%8) +: 32]);
        end
        if (wb_ack || line_valid) begin
          check_eq("pulse_wb_ack", wb_ack, cur_wb);
          check_eq("pulse_line_valid", line_valid, !cur_wb);
          check_eq("beat_count", beats, 8);
          check_eq("latency", cyc - a_exp, 9 + stalls);
          check_eq("done_mem_req", mem_req, 1'b0);
          if (!cur_wb) m_line = fill_line;
          check_eq("line_data", line_data, m_line);
          if (cur_wb) wb_req = 1'b0; else miss_req = 1'b0;
          void'(order.pop_front());
          if (order.size() != 0) begin
            cur_wb = order[0];
            base = (cur_wb ? wa : ma) & 32'hFFFF_FFE0;
          end
          a_exp = cyc + 2; beats = 0; stalls = 0; pat = 0; prev_stall = 1'b0;
          fill_line = m_line;
        end
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = (pat % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      mem_ready = r;
      mem_rdata = (mode == 0) ? 32'hA0 + 32'(beats) : $urandom;
      if (mem_req) begin
        pat++;
        if (r) begin
          if (!cur_wb) fill_line[32*(beats%8) +: 32] = mem_rdata;
          beats++;
          prev_stall = 1'b0;
        end else begin
          stalls++;
          prev_stall = 1'b1;
          prev_addr = mem_address; prev_we = mem_we; prev_wdata = mem_wdata;
        end
      end
    end
    if (order.size() != 0) check_eq("timeout_pending_txns", order.size(), 0);
    mem_ready = 1'b0;
    @(negedge clk);
    check_quiet("after_done");
    @(negedge clk);
    check_quiet("no_reaccept");
  endtask

  task automatic reset_mid_writeback();
    logic [31:0]  wa;
    logic [255:0] wd;
    int           guard;
    wa = $urandom;
    wd = rand_line();
    @(negedge clk);
    wb_req = 1'b1; wb_address = wa; wb_data = wd; miss_req = 1'b0; mem_ready = 1'b1;
    guard = 0;
    while (!(mem_req && mem_address[4:0] == 5'h10) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check_eq("reached_beat4", guard < 40, 1'b1);
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    m_line = '0;
    repeat (3) begin
      @(negedge clk);
      check_eq("reset_no_ack", wb_ack, 1'b0);
      check_eq("reset_no_req", mem_req, 1'b0);
    end
    run_txns(1'b1, 1'b0, wa, wd, 32'h0, 2);
  endtask

  initial begin
    logic [255:0] wd;
    int           kind;
    n_cmp = 0; n_bad = 0; m_line = '0;
    reset = 1'b1;
    miss_req = 1'b0; miss_address = '0;
    wb_req = 1'b0; wb_address = '0; wb_data = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");

    run_txns(1'b0, 1'b1, 32'h0, 256'h0, 32'h0000_1234, 0);
    check_eq("fill_word0", line_data[31:0], 32'hA0);
    check_eq("fill_word7", line_data[255:224], 32'hA7);

    for (int i = 0; i < 8; i++) wd[32*i +: 32] = 32'h1111_1111 * i;
    run_txns(1'b1, 1'b0, 32'h8000_00E0, wd, 32'h0, 0);

    run_txns(1'b1, 1'b1, $urandom, rand_line(), $urandom, 2);
    run_txns(1'b0, 1'b1, 32'h0, 256'h0, $urandom, 1);
    run_txns(1'b1, 1'b1, $urandom, rand_line(), $urandom, 1);

    reset_mid_writeback();

    for (int k = 0; k < 8; k++) begin
      kind = int'($urandom_range(0, 2));
      run_txns(kind != 1, kind != 0, $urandom, rand_line(), $urandom, int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dcache_line_controller.md
Name: dcache_line_controller

Overview:
- Memory-side stage directly downstream of the 2-way data cache. It takes the cache's dirty-line writeback (flush) requests and line-fill (miss) requests and serialises each 256-bit line into 8 single-word beats on a 32-bit memory bus.
- It returns the assembled fill line to the cache on line_data, which drives the cache's dm_data input.
- One transaction is in flight at a time. A writeback always completes before any fill is started.

Parameters:
- LINE_WORDS, 8, words per cache line; fixed to match the 256-bit line.
- WORD_WIDTH, 32, memory bus data width.
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- miss_req  in  1  level request for a line fill; held high by the cache until line_valid.
- miss_address  in  32  fill byte address; bits [4:0] are ignored.
- wb_req  in  1  level request for a writeback; corresponds to the cache's flush_done=0; held until wb_ack.
- wb_address  in  32  writeback line address; bits [4:0] are ignored.
- wb_data  in  256  writeback line; word i is bits [32i+:32].
- line_data  out  256  assembled fill line; feeds the cache's dm_data.
- line_valid  out  1  one-cycle pulse when line_data is complete.
- wb_ack  out  1  one-cycle pulse when the writeback has finished.
- busy  out  1  high in every state other than IDLE.
- mem_req  out  1  memory beat request.
- mem_we  out  1  1 = write beat, 0 = read beat.
- mem_address  out  32  word address of the current beat.
- mem_wdata  out  32  write data for the current beat.
- mem_ready  in  1  memory accepts or completes the current beat this cycle.
- mem_rdata  in  32  read data, valid when mem_ready=1 and mem_we=0.

Behaviour:
- Reset values:
  - All outputs 0, including line_data.
  - State IDLE, beat counter 0.
  - Internal address and data capture registers cleared.
  - Reset mid-burst aborts the transaction immediately; mem_req drops asynchronously.
  - No ack or valid pulse is produced for an aborted transaction.
- All outputs are registered.
- FSM states: IDLE, WB_BURST, FILL_BURST, DONE.
- IDLE:
  - If wb_req=1, capture base = {wb_address[31:5], 5'b0} and wb_data, then go to WB_BURST.
  - Else if miss_req=1, capture base = {miss_address[31:5], 5'b0}, then go to FILL_BURST.
  - If both are high in the same cycle, the writeback wins; miss_req stays pending and is taken after the writeback's DONE.
- WB_BURST:
  - mem_req=1, mem_we=1.
  - mem_address = base + 4*beat.
  - mem_wdata = captured word[beat].
- FILL_BURST:
  - mem_req=1, mem_we=0, mem_address = base + 4*beat.
  - On a completed beat, mem_rdata is written into line_data[32*beat +: 32].
- Beat handshake:
  - A beat completes on a rising edge where mem_req=1 and mem_ready=1.
  - mem_address, mem_we and mem_wdata stay stable until that beat completes.
  - The beat counter is 3 bits and increments only on completion.
  - Completion of beat 7 moves to DONE and clears the counter.
  - mem_ready while mem_req=0 is ignored.
- DONE (one cycle):
  - mem_req=0.
  - wb_ack=1 if the transaction was a writeback, else line_valid=1.
  - Requests are not sampled in DONE; the upstream drops its request while the pulse is high.
  - Next state is IDLE.
- line_data:
  - Holds its value after line_valid until the first beat of the next fill overwrites word 0.
  - Writebacks never modify line_data.
- Latency:
  - With mem_ready held at 1, the request is sampled at edge N, mem_req is high for 8 cycles, and the ack/valid pulse occurs in the cycle after edge N+9.
  - Each mem_ready=0 cycle adds one cycle of latency.
- Address wrap: base + 4*beat never carries out of bits [4:0], because base is line-aligned.
- Requests that change while busy are ignored; only the values captured in IDLE are used.

Test Plan:
- Fill with mem_ready=1, miss_address=0x0000_1234:
  - Required: mem_address = 0x1220, 0x1224, …, 0x123C with mem_we=0.
  - mem_rdata = 0xA0+i on beat i gives line_data word i = 0xA0+i.
  - line_valid is a single pulse 10 cycles after the request (accept edge + 9); busy falls the cycle after.
- Writeback with wb_address=0x8000_00E0 and wb_data words 0x11111111·i:
  - Required: 8 write beats to 0x800000E0..0x800000FC with matching mem_wdata.
  - Exactly one wb_ack pulse; line_data unchanged.
- Simultaneous wb_req and miss_req:
  - Required: the full writeback burst, then wb_ack, then one IDLE cycle, then the fill burst, then line_valid.
  - No interleaving of beats.
- Fill with mem_ready toggling 1,0,0,1,…:
  - Required: mem_address/mem_we held stable through every stall.
  - Beat count is exactly 8; line_data is correct.
  - Latency grows by the number of stall cycles.
- Reset asserted at beat 4 of a writeback:
  - Required: mem_req=0 and all outputs 0 immediately.
  - No wb_ack; after release, wb_req still high starts a fresh 8-beat writeback from beat 0.
- Request held high in DONE:
  - Required: no re-accept in the DONE cycle.
  - If the request is dropped during the pulse, the block returns to IDLE with busy=0 and mem_req stays 0.
